// File: rtl/elastic_pipe_buffer_pkg.sv
// Purpose: shared helpers for the elastic pipe buffer parameter checks.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package elastic_pipe_buffer_pkg;

   // True when v is a power of two and at least 2 (valid FIFO depth).
   function automatic bit is_pow2(input int v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Purpose: storage array for the elastic pipe buffer, 1 write / 1 read port.
// Latency: write lands at the rising edge; read is combinational from the array.
// Backpressure: none; the owner gates we.
// Ports: clk, we/waddr/wdata (clocked write), raddr/rdata (asynchronous read).
module fifo_regfile #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   // Contents are deliberately not reset; count/out_valid qualify them.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_pipe_buffer.sv
// Purpose: first-word-fall-through FIFO decoupling two valid/ready pipeline stages.
// Latency: a word pushed at edge N is visible on out_data with out_valid after edge N.
// Backpressure: in_ready drops when DEPTH words are held; depends on state only.
// Ports: clk, reset (async high), clear (sync flush), in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count (occupancy), almost_full (count >= AF_LEVEL).
module elastic_pipe_buffer
   import elastic_pipe_buffer_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   generate
      if (!is_pow2(DEPTH)) begin : g_depth_chk
         $error("elastic_pipe_buffer: DEPTH must be a power of two >= 2");
      end
      if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_af_chk
         $error("elastic_pipe_buffer: AF_LEVEL must lie in 1..DEPTH");
      end
   endgenerate

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  cnt_q;
   logic              push;
   logic              pop;

   assign in_ready    = !reset && (cnt_q != CNT_W'(DEPTH));
   assign out_valid   = (cnt_q != '0);
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign count       = cnt_q;
   assign almost_full = (cnt_q >= CNT_W'(AF_LEVEL));

   // Pointers wrap modulo DEPTH for free since DEPTH is a power of two.
   // clear wins over any handshake in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // A word offered during clear is dropped, so its write is suppressed too.
   fifo_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk   (clk),
      .we    (push && !clear),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
// Purpose: directed self-checking bench for elastic_pipe_buffer (WIDTH=32, DEPTH=4).
// Latency: inputs change 1ns after the rising edge; outputs are checked then.
// Backpressure: exercised through out_ready hold-off and full-buffer pushes.
module tb_elastic_pipe_buffer;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  count;
   logic        almost_full;

   int tests_run;
   int tests_failed;

   elastic_pipe_buffer #(
      .WIDTH    (32),
      .DEPTH    (4),
      .AF_LEVEL (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .count       (count),
      .almost_full (almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Occupancy must never leave 0..4.
   always @(negedge clk) begin
      if (!reset && (count > 3'd4)) begin
         check("count_bound", {29'd0, count}, 32'd4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [31:0] d, input logic ordy);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   int exp_val;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset     = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      // Reset state
      check("rst_count",     {29'd0, count}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      check("rst_af",        {31'd0, almost_full}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);

      // Fill A0..A3 with the consumer stalled
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'hA0 + i, 1'b0);
         tick();
         check("fill_count", {29'd0, count}, i + 1);
         check("fill_af",    {31'd0, almost_full}, (i + 1 >= 3) ? 32'd1 : 32'd0);
         check("fill_head",  out_data, 32'hA0);
      end
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("drain_data", out_data, 32'hA0 + i);
         tick();
      end
      check("drain_count",     {29'd0, count}, 32'd0);
      check("drain_out_valid", {31'd0, out_valid}, 32'd0);

      // Reset asserted mid-stream with three words held
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hB0 + i, 1'b0);
         tick();
      end
      check("pre_rst_count", {29'd0, count}, 32'd3);
      drive(1'b1, 32'hB3, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_count",     {29'd0, count}, 32'd0);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_in_ready",  {31'd0, in_ready}, 32'd0);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      reset = 1'b0;
      tick();
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_count",    {29'd0, count}, 32'd0);

      // Wrap-around: 10 rounds of push 3 / pop 3, values 0..29
      exp_val = 0;
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) begin
            drive(1'b1, r * 3 + k, 1'b0);
            tick();
         end
         drive(1'b0, 32'h0, 1'b1);
         for (int k = 0; k < 3; k++) begin
            check("wrap_data", out_data, exp_val);
            exp_val++;
            tick();
         end
      end
      drive(1'b0, 32'h0, 1'b0);
      check("wrap_count", {29'd0, count}, 32'd0);

      // Simultaneous push/pop at count=2
      drive(1'b1, 32'd100, 1'b0);
      tick();
      drive(1'b1, 32'd101, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'd102 + i, 1'b1);
         check("pp_data", out_data, 32'd100 + i);
         tick();
         check("pp_count", {29'd0, count}, 32'd2);
      end
      drive(1'b0, 32'h0, 1'b1);
      check("pp_tail0", out_data, 32'd108);
      tick();
      check("pp_tail1", out_data, 32'd109);
      tick();
      check("pp_empty", {29'd0, count}, 32'd0);

      // Full with both sides active: pop taken, push refused
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'd200 + i, 1'b0);
         tick();
      end
      drive(1'b1, 32'h999, 1'b1);
      check("full_rdy", {31'd0, in_ready}, 32'd0);
      check("full_head", out_data, 32'd200);
      tick();
      check("full_pop_count", {29'd0, count}, 32'd3);
      check("full_pop_rdy",   {31'd0, in_ready}, 32'd1);
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 1; i < 4; i++) begin
         check("full_drain", out_data, 32'd200 + i);
         tick();
      end
      check("full_drain_count", {29'd0, count}, 32'd0);

      // Clear with a push offered at count=2
      drive(1'b1, 32'd300, 1'b0);
      tick();
      drive(1'b1, 32'd301, 1'b0);
      tick();
      drive(1'b1, 32'd302, 1'b0);
      clear = 1'b1;
      #1;
      check("clr_cycle_in_ready",  {31'd0, in_ready}, 32'd1);
      check("clr_cycle_out_valid", {31'd0, out_valid}, 32'd1);
      tick();
      clear = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      check("clr_count",     {29'd0, count}, 32'd0);
      check("clr_out_valid", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 32'd303, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      check("clr_next_count", {29'd0, count}, 32'd1);
      check("clr_next_data",  out_data, 32'd303);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      check("clr_final_count", {29'd0, count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
